// File: rtl/ascensor_pkg.sv
// Shared types, output codes, button indices and request-decoding helpers
// for the four-floor elevator controller.
// Purely combinational helpers; no state lives here.
package ascensor_pkg;

  typedef enum logic [2:0] {
    REPOSO,
    ABRIENDO,
    ABIERTA,
    CERRANDO,
    MOVIENDO
  } estado_t;

  localparam logic [1:0] MOTOR_PARO      = 2'b00;
  localparam logic [1:0] MOTOR_SUBE      = 2'b01;
  localparam logic [1:0] MOTOR_BAJA      = 2'b10;

  localparam logic [1:0] PUERTA_MANTENER = 2'b00;
  localparam logic [1:0] PUERTA_ABRIR    = 2'b01;
  localparam logic [1:0] PUERTA_CERRAR   = 2'b10;

  localparam logic [1:0] DIR_NINGUNA     = 2'b00;
  localparam logic [1:0] DIR_SUBE        = 2'b01;
  localparam logic [1:0] DIR_BAJA        = 2'b10;

  localparam int IDX_P1_SUBE = 0;
  localparam int IDX_P2_BAJA = 1;
  localparam int IDX_P2_SUBE = 2;
  localparam int IDX_P3_BAJA = 3;
  localparam int IDX_P3_SUBE = 4;
  localparam int IDX_P4_BAJA = 5;
  localparam int IDX_CAB_P1  = 6;
  localparam int IDX_CAB_P2  = 7;
  localparam int IDX_CAB_P3  = 8;
  localparam int IDX_CAB_P4  = 9;

  // Hall-up call bit at floor f (none at the top floor).
  function automatic logic [9:0] llamada_sube(input logic [1:0] f);
    logic [9:0] m;
    m = '0;
    case (f)
      2'd0:    m[IDX_P1_SUBE] = 1'b1;
      2'd1:    m[IDX_P2_SUBE] = 1'b1;
      2'd2:    m[IDX_P3_SUBE] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Hall-down call bit at floor f (none at the bottom floor).
  function automatic logic [9:0] llamada_baja(input logic [1:0] f);
    logic [9:0] m;
    m = '0;
    case (f)
      2'd1:    m[IDX_P2_BAJA] = 1'b1;
      2'd2:    m[IDX_P3_BAJA] = 1'b1;
      2'd3:    m[IDX_P4_BAJA] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [9:0] cabina(input logic [1:0] f);
    return 10'b1 << (IDX_CAB_P1 + int'(f));
  endfunction

  // Every request bit that belongs to floor f.
  function automatic logic [9:0] mascara_piso(input logic [1:0] f);
    return cabina(f) | llamada_sube(f) | llamada_baja(f);
  endfunction

  function automatic logic hay_arriba(input logic [1:0] f, input logic [9:0] p);
    logic r;
    r = 1'b0;
    for (int g = 0; g < 4; g++) begin
      if (g > int'(f)) r = r | (|(mascara_piso(2'(g)) & p));
    end
    return r;
  endfunction

  function automatic logic hay_abajo(input logic [1:0] f, input logic [9:0] p);
    logic r;
    r = 1'b0;
    for (int g = 0; g < 4; g++) begin
      if (g < int'(f)) r = r | (|(mascara_piso(2'(g)) & p));
    end
    return r;
  endfunction

  // Requests answered by a stop at floor f travelling in direction sube.
  // The opposite hall call is only answered when nothing lies further on,
  // because the car is about to reverse there anyway.
  function automatic logic [9:0] servicio(input logic [1:0] f, input logic sube,
                                          input logic [9:0] p);
    logic [9:0] m;
    if (sube) begin
      m = cabina(f) | llamada_sube(f);
      if (!hay_arriba(f, p)) m = m | llamada_baja(f);
    end else begin
      m = cabina(f) | llamada_baja(f);
      if (!hay_abajo(f, p)) m = m | llamada_sube(f);
    end
    return m;
  endfunction

endpackage

// File: rtl/temporizador_puerta.sv
// Loadable down-counter shared by door dwell and close-timeout timing.
// Load takes priority over decrement; count saturates at zero.
// fin is high on the last counted cycle (count <= 1) and stays high at zero.
module temporizador_puerta #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         carga,
  input  logic [W-1:0] valor,
  input  logic         en,
  output logic         fin
);

  logic [W-1:0] cuenta;

  // Load a new interval or count down towards zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta <= '0;
    end else if (carga) begin
      cuenta <= valor;
    end else if (en && (cuenta != '0)) begin
      cuenta <= cuenta - 1'b1;
    end
  end

  assign fin = (cuenta <= W'(1));

endmodule

// File: rtl/controlador_ascensor.sv
// Collective (SCAN) elevator controller: latches requests, sequences doors and motor.
// Motor/door commands follow the state register; floor stop takes effect the cycle after cambio_piso.
// No backpressure: requests are latched every cycle; sensor glitches are flagged on aviso[1].
module controlador_ascensor #(
  parameter int T_ESPERA     = 100,
  parameter int T_CIERRE_MAX = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] botones,
  input  logic       cambio_piso,
  input  logic [1:0] boton_abrir_cerrar,
  input  logic       sensor_puertas,
  input  logic [1:0] puertas_abiertas,
  output logic [9:0] luces,
  output logic [1:0] display_num,
  output logic [1:0] display_dir,
  output logic [3:0] aviso,
  output logic [1:0] puertas,
  output logic [1:0] motor
);
  import ascensor_pkg::*;

  localparam int TMAX = (T_ESPERA > T_CIERRE_MAX) ? T_ESPERA : T_CIERRE_MAX;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] CARGA_ESPERA = TW'(T_ESPERA);
  localparam logic [TW-1:0] CARGA_CIERRE = TW'(T_CIERRE_MAX);

  estado_t    estado, estado_sig;
  logic [1:0] piso, piso_sig;
  logic       sube, sube_pref;
  logic [9:0] pendientes, limpiar, servicio_act;
  logic       error_sensor, llegada, llegar;
  logic       carga, en_cuenta, fin;
  logic [TW-1:0] valor;
  logic       abrir, cerrar, tope_abierta, tope_cerrada;
  logic       arriba, abajo, paso_ok, parar;

  assign abrir        = boton_abrir_cerrar[0];
  assign cerrar       = boton_abrir_cerrar[1];
  assign tope_abierta = puertas_abiertas[0];
  assign tope_cerrada = puertas_abiertas[1];

  assign arriba       = hay_arriba(piso, pendientes);
  assign abajo        = hay_abajo(piso, pendientes);
  assign servicio_act = servicio(piso, sube, pendientes);
  assign paso_ok      = sube ? (piso != 2'd3) : (piso != 2'd0);
  assign piso_sig     = sube ? (piso + 2'd1) : (piso - 2'd1);
  // Stop at the next floor if it serves a request, or unconditionally at the shaft ends.
  assign parar        = (|(servicio(piso_sig, sube, pendientes) & pendientes)) ||
                        (sube ? (piso_sig == 2'd3) : (piso_sig == 2'd0));
  // Keep direction while work lies ahead, otherwise reverse if work lies behind.
  assign sube_pref    = (sube ? arriba : abajo) ? sube :
                        ((sube ? abajo : arriba) ? ~sube : sube);

  temporizador_puerta #(.W(TW)) u_temporizador (
    .clk   (clk),
    .rst_n (rst_n),
    .carga (carga),
    .valor (valor),
    .en    (en_cuenta),
    .fin   (fin)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  // Next state, actuator commands, timer control and request clearing.
  always_comb begin
    estado_sig = estado;
    puertas    = PUERTA_MANTENER;
    motor      = MOTOR_PARO;
    carga      = 1'b0;
    valor      = CARGA_ESPERA;
    en_cuenta  = 1'b0;
    limpiar    = '0;
    llegar     = 1'b0;
    case (estado)
      REPOSO: begin
        if ((|(mascara_piso(piso) & pendientes)) || abrir) begin
          estado_sig = ABRIENDO;
        end else if (arriba || abajo) begin
          estado_sig = CERRANDO;
          carga      = 1'b1;
          valor      = CARGA_CIERRE;
        end
      end
      CERRANDO: begin
        puertas   = PUERTA_CERRAR;
        en_cuenta = 1'b1;
        if (sensor_puertas || abrir) begin
          estado_sig = ABRIENDO;
        end else if (tope_cerrada) begin
          estado_sig = (arriba || abajo) ? MOVIENDO : REPOSO;
        end
      end
      MOVIENDO: begin
        motor = sube ? MOTOR_SUBE : MOTOR_BAJA;
        if (cambio_piso && paso_ok && parar) begin
          estado_sig = ABRIENDO;
          llegar     = 1'b1;
        end
      end
      ABRIENDO: begin
        puertas = PUERTA_ABRIR;
        if (tope_abierta) begin
          estado_sig = ABIERTA;
          limpiar    = servicio_act;
          carga      = 1'b1;
        end
      end
      ABIERTA: begin
        en_cuenta = 1'b1;
        // Presses answered by the open door are swallowed rather than latched.
        limpiar   = servicio_act;
        if (abrir || (|(botones & servicio_act))) begin
          carga = 1'b1;
        end else if ((fin || cerrar) && !sensor_puertas) begin
          estado_sig = CERRANDO;
          carga      = 1'b1;
          valor      = CARGA_CIERRE;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // Request latch: new presses set, the current stop's service set clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pendientes <= '0;
    else        pendientes <= (pendientes | botones) & ~limpiar;
  end

  // Floor tracking, sticky sensor error and one-cycle arrival pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piso         <= 2'd0;
      error_sensor <= 1'b0;
      llegada      <= 1'b0;
    end else begin
      llegada <= llegar;
      if (cambio_piso) begin
        if ((estado == MOVIENDO) && paso_ok) piso <= piso_sig;
        else                                 error_sensor <= 1'b1;
      end
    end
  end

  // Travel direction is only re-chosen while the car is stationary with doors shut or shutting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sube <= 1'b1;
    end else if ((estado == REPOSO) || (estado == CERRANDO)) begin
      sube <= sube_pref;
    end
  end

  // Direction indicator is blank when idle with no work.
  always_comb begin
    display_dir = sube ? DIR_SUBE : DIR_BAJA;
    if ((pendientes == '0) && (estado != MOVIENDO)) display_dir = DIR_NINGUNA;
  end

  assign luces       = pendientes;
  assign display_num = piso;
  assign aviso       = {estado == ABIERTA, llegada, error_sensor, (estado == CERRANDO) && fin};

endmodule

// File: doc/controlador_ascensor.md
# controlador_ascensor

Sequencing controller for the four-floor elevator: latches hall and cabin requests, selects travel direction with a collective (SCAN) policy, and drives motor and door commands from floor-sensor and door-limit feedback. Sits between the button/sensor inputs and the actuator/display outputs of the top level. It owns all request state, so no separate request register is instantiated alongside it.

## Interface
- T_ESPERA, 100: door dwell time in clock cycles once fully open (≥2).
- T_CIERRE_MAX, 1000: cycles allowed in CERRANDO before aviso[0] is raised.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- botones  in  10  request pulses/levels. Bit index: 0 p1↑, 1 p2↓, 2 p2↑, 3 p3↓, 4 p3↑, 5 p4↓, 6..9 cabin p1..p4.
- cambio_piso  in  1  one-cycle pulse per floor sensor crossed.
- boton_abrir_cerrar  in  2  [0] open, [1] close.
- sensor_puertas  in  1  door obstruction, level.
- puertas_abiertas  in  2  [0] fully open, [1] fully closed (limit switches).
- luces  out  10  pending-request lamps, same indexing as botones.
- display_num  out  2  current floor, 0..3 = p1..p4.
- display_dir  out  2  01 up, 10 down, 00 idle.
- aviso  out  4  [0] door obstructed/close timeout, [1] sensor error, [2] arrival pulse, [3] doors open.
- puertas  out  2  01 open, 10 close, 00 hold.
- motor  out  2  01 up, 10 down, 00 stop. 11 never driven.

## Operation
- pendientes[9:0] register; set bit |= botones every cycle; luces = pendientes.
- Service set at floor f in direction d: cabin f, hall-d at f; hall-opposite at f also if no pending request beyond f in d.
- States: REPOSO, ABRIENDO, ABIERTA, CERRANDO, MOVIENDO.
- REPOSO: request at current floor → ABRIENDO. Else request above/below → CERRANDO. Prefer keeping last direction; if none ahead, reverse. Nothing pending → stay, display_dir=00.
- CERRANDO: puertas=10. puertas_abiertas[1] → MOVIENDO. sensor_puertas or open button → ABRIENDO. Counter ≥ T_CIERRE_MAX → aviso[0]=1 until closed.
- MOVIENDO: motor = dir. On cambio_piso, floor ±1. New floor in service set → motor 00, ABRIENDO, aviso[2] pulse.
- ABRIENDO: puertas=01. puertas_abiertas[0] → ABIERTA. Clear the service set for the current floor/direction. Load dwell counter with T_ESPERA.
- ABIERTA: puertas=00, aviso[3]=1. Counter decrements. Expiry or close button (without obstruction) → CERRANDO. Open button or new press of a current-floor service bit reloads the counter; that bit is cleared, not latched.
- Open and close pressed together: open wins. Press of a non-current-floor bit during a clear: set wins.
- cambio_piso while motor=00, or a step that would leave 0..3: ignored, floor saturates, aviso[1] sticky until reset.
- Invalid bits ignored: none exist at the ends (p1↓, p4↑ absent by encoding).

## Timing
- Reset (async): state REPOSO, floor 0, internal dir up, pendientes 0. All outputs 0; motor stops immediately, including mid-travel.
- Press at cycle n → luces bit high at n+1.
- Decision latency: REPOSO with pending request → CERRANDO at n+2 after press.
- cambio_piso at n → display_num updated and motor 00 (if stopping) at n+1.
- puertas_abiertas[0] at n → ABIERTA and clear at n+1. CERRANDO entered T_ESPERA cycles later absent reloads.
- aviso[2]: exactly one cycle per stop.

## Structure
- Package ascensor_pkg: state enum, MOTOR_/PUERTA_/DIR_ codes, button index constants (IDX_P1_SUBE … IDX_CAB_P4).
- One sub-module, temporizador_puerta: loadable down-counter with done flag, reused for dwell and close timeout.
- Service-set and ahead/behind logic as combinational functions in the package.

## Test plan
- Reset, press cabin p3 (bit 8): CERRANDO → closed limit → motor=01; two cambio_piso pulses → display_num=2, motor=00, puertas=01, aviso[2] one pulse, bit 8 cleared at open.
- At p2 going up with bits 1 (p2↓) and 4 (p3↑) pending: stop at p2 does not clear bit 1. Continue to p3, clear bit 4. Reverse; on return to p2, clear bit 1.
- Obstruction in CERRANDO: sensor_puertas=1 → puertas=01 next cycle. Hold closed limit low for T_CIERRE_MAX → aviso[0]=1.
- ABIERTA with open button at dwell count 3: counter reloads to T_ESPERA. Simultaneous open+close → remains open.
- cambio_piso with motor=00, or at floor 3 going up: floor unchanged, aviso[1]=1 sticky.
- rst_n low while motor=01 with pending requests: motor=00, luces=0, display_num=0 asynchronously.
